// File: rtl/lram_writer_pkg.sv
// Shared constants, FSM state type and INIT bit-plane helper for the LUTRAM writer.
package lram_writer_pkg;

   localparam int unsigned DEPTH  = 64;
   localparam int unsigned ADDR_W = 6;
   localparam int unsigned DATA_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // RAM64M8 stores bit b of every byte in its own 64-bit INIT plane.
   function automatic logic [DEPTH-1:0] init_plane(input logic [DEPTH*DATA_W-1:0] init,
                                                   input int unsigned b);
      logic [DEPTH-1:0] p;
      p = '0;
      for (int unsigned k = 0; k < DEPTH; k++)
         p[k] = init[DATA_W*k + b];
      return p;
   endfunction

endpackage

// File: rtl/lram_array.sv
// 64x8 LUTRAM built from one placed RAM64M8; all ports share a single address.
import lram_writer_pkg::*;

module lram_array #(
   parameter LOC = "SLICE_X1Y1",
   parameter logic [DEPTH*DATA_W-1:0] INIT = '0
) (
   input  logic              clock,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   (* LOC = LOC, BEL = "H6LUT" *)
   RAM64M8 #(
      .INIT_A(init_plane(INIT, 0)),
      .INIT_B(init_plane(INIT, 1)),
      .INIT_C(init_plane(INIT, 2)),
      .INIT_D(init_plane(INIT, 3)),
      .INIT_E(init_plane(INIT, 4)),
      .INIT_F(init_plane(INIT, 5)),
      .INIT_G(init_plane(INIT, 6)),
      .INIT_H(init_plane(INIT, 7))
   ) u_ram (
      .DOA  (rdata[0]),
      .DOB  (rdata[1]),
      .DOC  (rdata[2]),
      .DOD  (rdata[3]),
      .DOE  (rdata[4]),
      .DOF  (rdata[5]),
      .DOG  (rdata[6]),
      .DOH  (rdata[7]),
      .DIA  (wdata[0]),
      .DIB  (wdata[1]),
      .DIC  (wdata[2]),
      .DID  (wdata[3]),
      .DIE  (wdata[4]),
      .DIF  (wdata[5]),
      .DIG  (wdata[6]),
      .DIH  (wdata[7]),
      .ADDRA(addr),
      .ADDRB(addr),
      .ADDRC(addr),
      .ADDRD(addr),
      .ADDRE(addr),
      .ADDRF(addr),
      .ADDRG(addr),
      .ADDRH(addr),
      .WE   (we),
      .WCLK (clock)
   );

endmodule

// File: rtl/ram64m8.sv
// Behavioural model of the RAM64M8 LUTRAM primitive: 8 x 64-bit planes, sync write, async read.
module RAM64M8 #(
   parameter logic [63:0] INIT_A = 64'h0,
   parameter logic [63:0] INIT_B = 64'h0,
   parameter logic [63:0] INIT_C = 64'h0,
   parameter logic [63:0] INIT_D = 64'h0,
   parameter logic [63:0] INIT_E = 64'h0,
   parameter logic [63:0] INIT_F = 64'h0,
   parameter logic [63:0] INIT_G = 64'h0,
   parameter logic [63:0] INIT_H = 64'h0
) (
   output logic       DOA,
   output logic       DOB,
   output logic       DOC,
   output logic       DOD,
   output logic       DOE,
   output logic       DOF,
   output logic       DOG,
   output logic       DOH,
   input  logic       DIA,
   input  logic       DIB,
   input  logic       DIC,
   input  logic       DID,
   input  logic       DIE,
   input  logic       DIF,
   input  logic       DIG,
   input  logic       DIH,
   input  logic [5:0] ADDRA,
   input  logic [5:0] ADDRB,
   input  logic [5:0] ADDRC,
   input  logic [5:0] ADDRD,
   input  logic [5:0] ADDRE,
   input  logic [5:0] ADDRF,
   input  logic [5:0] ADDRG,
   input  logic [5:0] ADDRH,
   input  logic       WE,
   input  logic       WCLK
);

   logic [63:0] mem_a = INIT_A;
   logic [63:0] mem_b = INIT_B;
   logic [63:0] mem_c = INIT_C;
   logic [63:0] mem_d = INIT_D;
   logic [63:0] mem_e = INIT_E;
   logic [63:0] mem_f = INIT_F;
   logic [63:0] mem_g = INIT_G;
   logic [63:0] mem_h = INIT_H;

   // The write address of every plane is ADDRH, as on the real primitive.
   always_ff @(posedge WCLK) begin
      if (WE) begin
         mem_a[ADDRH] <= DIA;
         mem_b[ADDRH] <= DIB;
         mem_c[ADDRH] <= DIC;
         mem_d[ADDRH] <= DID;
         mem_e[ADDRH] <= DIE;
         mem_f[ADDRH] <= DIF;
         mem_g[ADDRH] <= DIG;
         mem_h[ADDRH] <= DIH;
      end
   end

   assign DOA = mem_a[ADDRA];
   assign DOB = mem_b[ADDRB];
   assign DOC = mem_c[ADDRC];
   assign DOD = mem_d[ADDRD];
   assign DOE = mem_e[ADDRE];
   assign DOF = mem_f[ADDRF];
   assign DOG = mem_g[ADDRG];
   assign DOH = mem_h[ADDRH];

endmodule

// File: rtl/lram_writer.sv
// Streams a session of len+1 bytes into a LUTRAM, then frees the RAM for reads.
import lram_writer_pkg::*;

module lram_writer #(
   parameter LOC = "SLICE_X1Y1",
   parameter logic [511:0] INIT = 512'h0
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [5:0] len,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic       busy,
   output logic       done,
   output logic [6:0] count,
   input  logic [5:0] addr,
   output logic [7:0] data
);

   state_t            state;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] len_latched;
   logic [ADDR_W-1:0] ram_addr;
   logic              we;

   // in_ready is a registered copy of (state == ST_LOAD), so it gates the write directly.
   assign we       = in_ready & in_valid;
   assign ram_addr = busy ? wr_ptr : addr;

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= ST_IDLE;
         wr_ptr      <= '0;
         count       <= '0;
         len_latched <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         in_ready    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  len_latched <= len;
                  wr_ptr      <= '0;
                  count       <= '0;
                  busy        <= 1'b1;
                  in_ready    <= 1'b1;
                  state       <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (in_valid) begin
                  count <= count + 7'd1;
                  // Pointer holds on the final byte so a 64-byte session never wraps.
                  if (wr_ptr == len_latched) begin
                     in_ready <= 1'b0;
                     done     <= 1'b1;
                     state    <= ST_DONE;
                  end else begin
                     wr_ptr <= wr_ptr + 6'd1;
                  end
               end
            end
            ST_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               busy     <= 1'b0;
               done     <= 1'b0;
               in_ready <= 1'b0;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

   lram_array #(
      .LOC (LOC),
      .INIT(INIT)
   ) u_array (
      .clock(clock),
      .we   (we),
      .addr (ram_addr),
      .wdata(in_data),
      .rdata(data)
   );

endmodule

// File: tb/tb_lram_writer.sv
// Directed bench for lram_writer: sessions, stalls, ignored start, reset mid-load, INIT readback.
module tb_lram_writer;

   localparam logic [511:0] INIT_V = 512'h5A00_3322_0000;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic [5:0] len = '0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = '0;
   logic       in_ready;
   logic       busy;
   logic       done;
   logic [6:0] count;
   logic [5:0] addr = '0;
   logic [7:0] data;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   lram_writer #(
      .LOC ("SLICE_X1Y1"),
      .INIT(INIT_V)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .start   (start),
      .len     (len),
      .in_valid(in_valid),
      .in_data (in_data),
      .in_ready(in_ready),
      .busy    (busy),
      .done    (done),
      .count   (count),
      .addr    (addr),
      .data    (data)
   );

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic rd(input string tag, input logic [5:0] a, input logic [7:0] exp);
      addr = a;
      #1;
      chk(tag, {24'h0, data}, {24'h0, exp});
   endtask

   initial begin
      int nb;
      int i;

      // reset state
      reset = 1'b1; step(); reset = 1'b0;
      chk("rst_busy", {31'h0, busy}, 32'd0);
      chk("rst_done", {31'h0, done}, 32'd0);
      chk("rst_ready", {31'h0, in_ready}, 32'd0);
      chk("rst_count", {25'h0, count}, 32'd0);

      // INIT contents visible straight after reset
      rd("init_b5", 6'd5, 8'h5A);
      rd("init_b2", 6'd2, 8'h22);
      rd("init_b3", 6'd3, 8'h33);

      // reset beats start in the same cycle
      reset = 1'b1; start = 1'b1; len = 6'd3; step();
      reset = 1'b0; start = 1'b0;
      chk("rst_over_start", {31'h0, busy}, 32'd0);

      // reset after 2 of 4 bytes
      start = 1'b1; len = 6'd3; step(); start = 1'b0;
      in_valid = 1'b1; in_data = 8'h11; step();
      in_data = 8'h12; step();
      in_valid = 1'b0; reset = 1'b1; step(); reset = 1'b0;
      chk("midrst_busy", {31'h0, busy}, 32'd0);
      chk("midrst_count", {25'h0, count}, 32'd0);
      chk("midrst_ready", {31'h0, in_ready}, 32'd0);
      rd("midrst_a0", 6'd0, 8'h11);
      rd("midrst_a1", 6'd1, 8'h12);
      rd("midrst_a2", 6'd2, 8'h22);
      rd("midrst_a3", 6'd3, 8'h33);

      // basic 4-byte session, back-to-back
      start = 1'b1; len = 6'd3; step(); start = 1'b0;
      chk("s1_busy", {31'h0, busy}, 32'd1);
      chk("s1_ready", {31'h0, in_ready}, 32'd1);
      chk("s1_count0", {25'h0, count}, 32'd0);
      in_valid = 1'b1;
      in_data = 8'hA1; step();
      in_data = 8'hB2; step();
      in_data = 8'hC3; step();
      chk("s1_nodone3", {31'h0, done}, 32'd0);
      in_data = 8'hD4; step();
      in_valid = 1'b0;
      chk("s1_done", {31'h0, done}, 32'd1);
      chk("s1_count", {25'h0, count}, 32'd4);
      chk("s1_busy_done", {31'h0, busy}, 32'd1);
      chk("s1_ready_done", {31'h0, in_ready}, 32'd0);
      step();
      chk("s1_done_pulse", {31'h0, done}, 32'd0);
      chk("s1_idle_busy", {31'h0, busy}, 32'd0);
      chk("s1_count_hold", {25'h0, count}, 32'd4);
      rd("s1_a0", 6'd0, 8'hA1);
      rd("s1_a1", 6'd1, 8'hB2);
      rd("s1_a2", 6'd2, 8'hC3);
      rd("s1_a3", 6'd3, 8'hD4);
      rd("s1_a4_keep", 6'd4, 8'h00);
      rd("s1_a5_keep", 6'd5, 8'h5A);

      // len=1 with 2-cycle in_valid gaps
      start = 1'b1; len = 6'd1; step(); start = 1'b0;
      in_valid = 1'b1; in_data = 8'h77; step();
      in_valid = 1'b0; in_data = 8'h99; step(); step();
      chk("gap_count", {25'h0, count}, 32'd1);
      chk("gap_nodone", {31'h0, done}, 32'd0);
      chk("gap_busy", {31'h0, busy}, 32'd1);
      in_valid = 1'b1; in_data = 8'h88; step();
      in_valid = 1'b0;
      chk("gap_done", {31'h0, done}, 32'd1);
      chk("gap_count2", {25'h0, count}, 32'd2);
      step();
      rd("gap_a0", 6'd0, 8'h77);
      rd("gap_a1", 6'd1, 8'h88);
      rd("gap_a2_keep", 6'd2, 8'hC3);

      // start re-pulsed mid-load is ignored
      start = 1'b1; len = 6'd3; step(); start = 1'b0;
      in_valid = 1'b1; in_data = 8'h01; step();
      start = 1'b1; len = 6'd0; in_data = 8'h02; step();
      start = 1'b0;
      chk("restart_count", {25'h0, count}, 32'd2);
      chk("restart_nodone", {31'h0, done}, 32'd0);
      chk("restart_busy", {31'h0, busy}, 32'd1);
      in_data = 8'h03; step();
      in_data = 8'h04; step();
      in_valid = 1'b0;
      chk("restart_done", {31'h0, done}, 32'd1);
      chk("restart_count4", {25'h0, count}, 32'd4);
      step(); step();
      chk("restart_hold", {25'h0, count}, 32'd4);
      rd("restart_a1", 6'd1, 8'h02);
      rd("restart_a3", 6'd3, 8'h04);

      // full 64-byte session, data equals index
      start = 1'b1; len = 6'd63; step(); start = 1'b0;
      nb = 0;
      i = 0;
      while (busy && nb < 100) begin
         nb++;
         if (i < 64) begin
            in_valid = 1'b1;
            in_data = 8'(i);
         end else begin
            in_valid = 1'b0;
         end
         step();
         i++;
      end
      in_valid = 1'b0;
      chk("full_busy_cycles", nb, 32'd65);
      chk("full_count", {25'h0, count}, 32'd64);
      for (int k = 0; k < 64; k++)
         rd("full_rd", 6'(k), 8'(k));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lram_writer.md
LRAM_WRITER -- requirements
Module: lram_writer

Interface
REQ-001 SHALL have parameter LOC, default "SLICE_X1Y1", giving the placement constraint applied to the LUTRAM primitive.
REQ-002 SHALL have parameter INIT, default 512'h0, giving the power-up contents (byte k at bits 8k+7:8k).
REQ-003 SHALL have port clock, input, 1 bit; the only clock, and the LUTRAM write clock.
REQ-004 SHALL have port reset, input, 1 bit; synchronous, active-high.
REQ-005 SHALL have port start, input, 1 bit; requests a load session.
REQ-006 SHALL have port len, input, 6 bits; session length minus one (0 means 1 byte, 63 means 64 bytes), sampled when start is accepted.
REQ-007 SHALL have port in_valid, input, 1 bit; write-data valid.
REQ-008 SHALL have port in_data, input, 8 bits; byte to store.
REQ-009 SHALL have port in_ready, output, 1 bit; writer accepts in_data.
REQ-010 SHALL have port busy, output, 1 bit; load session in progress.
REQ-011 SHALL have port done, output, 1 bit; one-cycle pulse when a session completes.
REQ-012 SHALL have port count, output, 7 bits; bytes written in the current or last session.
REQ-013 SHALL have port addr, input, 6 bits; read address.
REQ-014 SHALL have port data, output, 8 bits; read data.

Function
REQ-015 SHALL implement a 3-state FSM: IDLE, LOAD, DONE.
REQ-016 IDLE->LOAD when start=1; len is latched and wr_ptr and count are cleared to 0.
REQ-017 In LOAD, in_ready SHALL be 1; elsewhere in_ready SHALL be 0.
REQ-018 A byte SHALL be accepted on the rising edge where in_valid=1 and in_ready=1: the RAM is written at wr_ptr, and wr_ptr and count are incremented.
REQ-019 LOAD->DONE on the acceptance where wr_ptr==len_latched; wr_ptr SHALL NOT wrap within a session.
REQ-020 DONE SHALL last exactly one cycle with done=1, then go to IDLE.
REQ-021 busy SHALL be 1 in LOAD and DONE, and 0 in IDLE.
REQ-022 start SHALL be ignored while busy=1.
REQ-023 in_valid=0 in LOAD SHALL stall with no write and no state change; there is no timeout.
REQ-024 The RAM write SHALL take effect at the accepting edge; data SHALL be combinational from the RAM at the selected address (0-cycle read latency).
REQ-025 The shared RAM address SHALL be wr_ptr while busy=1 and addr while busy=0; data is don't-care while busy=1.
REQ-026 Bytes not written in a session SHALL retain their prior contents.
REQ-027 count SHALL hold its final value (len+1) after DONE until the next accepted start.

Reset
REQ-028 reset SHALL force, on the next edge: state=IDLE, wr_ptr=0, count=0, len_latched=0, busy=0, done=0, in_ready=0.
REQ-029 RAM contents SHALL NOT be cleared by reset; bytes written before reset remain, including after a reset mid-LOAD.
REQ-030 reset SHALL override start and in_valid in the same cycle.

Structure
REQ-031 Package lram_writer_pkg SHALL hold DEPTH=64, ADDR_W=6, DATA_W=8 and the FSM state enum.
REQ-032 Sub-module lram_array SHALL wrap one RAM64M8, with all eight port addresses tied to the shared address, DIA..DIH=wdata[0..7], WE=we, WCLK=clock, and the LOC/BEL attributes.
REQ-033 The top level SHALL contain the FSM, wr_ptr, len_latched, count and the address mux only.

Verification
REQ-034 Scenario: reset, start with len=3, then bytes 0xA1,0xB2,0xC3,0xD4 back-to-back -> done pulses 1 cycle after 0xD4; count=4; addr 0..3 reads A1,B2,C3,D4.
REQ-035 Scenario: len=63 with 64 bytes equal to their index -> every address k reads k; busy is high for exactly 65 cycles.
REQ-036 Scenario: in_valid gaps of 2 cycles between bytes (len=1) -> no extra writes; done only after the 2nd byte.
REQ-037 Scenario: start pulsed again mid-LOAD -> ignored; count continues unchanged.
REQ-038 Scenario: reset after 2 of 4 bytes -> busy=0, count=0 next cycle; addr 0,1 return the written bytes; addr 2,3 return old/INIT values.
REQ-039 Scenario: INIT byte 5=0x5A with no session -> addr=5 reads 0x5A immediately after reset.
